// File: rtl/vga_framebuffer_fetch.sv
// Frame-buffer fetcher: issues credit-limited AXI read bursts over a frame and streams beats into a pixel FIFO.
// Optional feature macro VGA_FETCH_RESP_CHECK_EN: non-OKAY read responses set a sticky error and push zero pixels.
module vga_framebuffer_fetch #(
  parameter int  BURST_LEN       = 16,
  parameter int  FIFO_DEPTH      = 1023,
  parameter int  MAX_OUTSTANDING = 2,
  localparam int CW              = $clog2(FIFO_DEPTH + 1),
  localparam int OW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          enable_i,
  input  logic [31:0]   frame_base_i,
  input  logic [31:0]   frame_size_i,
  output logic          axi_arvalid_o,
  input  logic          axi_arready_i,
  output logic [31:0]   axi_araddr_o,
  output logic [7:0]    axi_arlen_o,
  output logic [1:0]    axi_arburst_o,
  output logic [3:0]    axi_arid_o,
  input  logic          axi_rvalid_i,
  output logic          axi_rready_o,
  input  logic [31:0]   axi_rdata_i,
  input  logic [1:0]    axi_rresp_i,
  input  logic          axi_rlast_i,
  output logic [31:0]   fifo_data_o,
  output logic          fifo_push_o,
  input  logic          fifo_accept_i,
  input  logic          fifo_pop_i,
  output logic          frame_start_o,
  output logic          error_o,
  output logic [1:0]    dbg_state_o,
  output logic [CW-1:0] dbg_credit_o
);

  // dbg_state_o encoding: 0 = IDLE, 1 = ACTIVE, 2 = DRAIN.
  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DRAIN = 2'd2} state_e;

  localparam logic [31:0]   BURST_BYTES = 32'(BURST_LEN * 4);
  localparam logic [CW:0]   BURST_W     = (CW + 1)'(BURST_LEN);
  localparam logic [CW:0]   DEPTH_W     = (CW + 1)'(FIFO_DEPTH);
  localparam logic [OW-1:0] MAX_OUT_W   = OW'(MAX_OUTSTANDING);

  state_e        state_q;
  logic [31:0]   base_q, size_q, offset_q, araddr_q, next_off;
  logic          arvalid_q;
  logic [CW-1:0] credit_q, credit_d;
  logic [CW:0]   credit_sum;
  logic [OW-1:0] out_q, out_d;
  logic          ar_hs, r_hs, rlast_hs, can_issue;

  // Handshakes complete on a rising edge where valid and ready are both high; a raised
  // valid with its payload is never withdrawn or altered until that edge.
  assign ar_hs    = arvalid_q & axi_arready_i;
  assign r_hs     = axi_rvalid_i & fifo_accept_i;
  assign rlast_hs = r_hs & axi_rlast_i;
  assign next_off = offset_q + BURST_BYTES;

  assign can_issue = (state_q == ACTIVE) && enable_i && !arvalid_q &&
                     ({1'b0, credit_q} >= BURST_W) && (out_q < MAX_OUT_W);

  always_comb begin
    credit_sum = {1'b0, credit_q} + (CW + 1)'(fifo_pop_i);
    if (ar_hs) credit_sum = credit_sum - BURST_W;
    // Pops beyond the FIFO capacity cannot return more credit than exists.
    credit_d = (credit_sum > DEPTH_W) ? DEPTH_W[CW-1:0] : credit_sum[CW-1:0];
  end

  always_comb begin
    out_d = out_q;
    if (ar_hs && !rlast_hs)
      out_d = out_q + OW'(1);
    else if (!ar_hs && rlast_hs && out_q != '0)
      out_d = out_q - OW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      base_q    <= '0;
      size_q    <= '0;
      offset_q  <= '0;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      credit_q  <= DEPTH_W[CW-1:0];
      out_q     <= '0;
    end else begin
      credit_q <= credit_d;
      out_q    <= out_d;
      case (state_q)
        IDLE: if (enable_i) begin
          state_q  <= ACTIVE;
          base_q   <= frame_base_i;
          size_q   <= frame_size_i;
          offset_q <= '0;
        end
        ACTIVE: if (!enable_i) state_q <= DRAIN;
        // A request still waiting for arready must complete before going idle.
        DRAIN: if (out_q == '0 && !arvalid_q) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (ar_hs) begin
        arvalid_q <= 1'b0;
        if (next_off >= size_q) begin
          offset_q <= '0;
          base_q   <= frame_base_i;
          size_q   <= frame_size_i;
        end else begin
          offset_q <= next_off;
        end
      end else if (can_issue) begin
        arvalid_q <= 1'b1;
        araddr_q  <= base_q + offset_q;
      end
    end
  end

  assign axi_arvalid_o = arvalid_q;
  assign axi_araddr_o  = araddr_q;
  assign axi_arlen_o   = 8'(BURST_LEN - 1);
  assign axi_arburst_o = 2'b01;
  assign axi_arid_o    = 4'd0;
  assign axi_rready_o  = fifo_accept_i;
  assign fifo_push_o   = r_hs;
  assign frame_start_o = ar_hs && (offset_q == '0);
  assign dbg_state_o   = state_q;
  assign dbg_credit_o  = credit_q;

`ifdef VGA_FETCH_RESP_CHECK_EN
  logic error_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      error_q <= 1'b0;
    else if (r_hs && axi_rresp_i != 2'b00)
      error_q <= 1'b1;
  end

  assign error_o     = error_q;
  assign fifo_data_o = (axi_rresp_i != 2'b00) ? 32'h0 : axi_rdata_i;
`else
  logic unused_resp;

  assign unused_resp = ^axi_rresp_i;
  assign error_o     = 1'b0;
  assign fifo_data_o = axi_rdata_i;
`endif

endmodule

// File: tb/tb_vga_framebuffer_fetch.sv
// Bench for vga_framebuffer_fetch: AXI read slave, pixel FIFO consumer and a frame-level reference model.
module tb_vga_framebuffer_fetch;
  localparam int BL    = 16;
  localparam int DEPTH = 1023;
  localparam int MO    = 2;
`ifdef VGA_FETCH_RESP_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        enable = 1'b0;
  logic [31:0] frame_base = '0, frame_size = '0;
  logic        arvalid, rready, rlast = 1'b0, rvalid = 1'b0, arready = 1'b0;
  logic [31:0] araddr, fdata, rdata = '0;
  logic [7:0]  arlen;
  logic [1:0]  arburst, rresp = '0, dbg_state;
  logic [3:0]  arid;
  logic        fpush, faccept = 1'b1, fpop = 1'b0, fstart, err;
  logic [9:0]  dbg_credit;

  vga_framebuffer_fetch dut (
    .clk_i(clk), .rst_i(rst_n), .enable_i(enable),
    .frame_base_i(frame_base), .frame_size_i(frame_size),
    .axi_arvalid_o(arvalid), .axi_arready_i(arready), .axi_araddr_o(araddr),
    .axi_arlen_o(arlen), .axi_arburst_o(arburst), .axi_arid_o(arid),
    .axi_rvalid_i(rvalid), .axi_rready_o(rready), .axi_rdata_i(rdata),
    .axi_rresp_i(rresp), .axi_rlast_i(rlast),
    .fifo_data_o(fdata), .fifo_push_o(fpush), .fifo_accept_i(faccept),
    .fifo_pop_i(fpop), .frame_start_o(fstart), .error_o(err),
    .dbg_state_o(dbg_state), .dbg_credit_o(dbg_credit)
  );

  int n_vec = 0, n_err = 0;

  // reference model
  int          m_credit = DEPTH, m_out = 0;
  logic [31:0] m_base = '0, m_size = '0, m_off = '0;
  logic        m_err = 1'b0;
  logic [31:0] exp_q[$];
  logic        p_valid = 1'b0, p_hs = 1'b0, p_en = 1'b0;
  logic [31:0] p_addr = '0;
  int          p_credit = DEPTH, p_out = 0;
  int          n_ar = 0, n_rlast = 0, n_push = 0, n_rlast_at_ar3 = -1;
  logic [31:0] ar_log[$];

  // slave / consumer controls
  logic [31:0] s_q[$];
  int          s_beat = 0, cyc = 0;
  logic        ar_rdy = 1'b1, r_on = 1'b0, pop_on = 1'b0, acc_tog = 1'b0;
  int          pop_req = 0, pop_done = 0, err_req = 0, err_done = 0;
  logic        s_ar_hs = 1'b0, s_r_hs = 1'b0, s_err_inj = 1'b0;
  logic [31:0] s_ar_addr = '0;

  function automatic logic [31:0] pix(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] log_at(input int i);
    if (i >= 0 && i < ar_log.size()) return ar_log[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard and per-cycle comparison, sampled on the falling edge
  task automatic model_cycle();
    logic        ar_hs, r_hs;
    logic [31:0] e;
    ar_hs     = arvalid && arready;
    r_hs      = rvalid && faccept;
    s_ar_hs   = ar_hs;
    s_ar_addr = araddr;
    s_r_hs    = r_hs;
    s_err_inj = (rresp != 2'b00);
    check("rready", 32'(rready), 32'(faccept));
    check("push", 32'(fpush), 32'(r_hs));
    if (r_hs) begin
      if (exp_q.size() == 0) begin
        check("sb_empty_on_push", 32'(exp_q.size()), 32'(1));
      end else begin
        e = exp_q.pop_front();
`ifdef VGA_FETCH_RESP_CHECK_EN
        if (rresp != 2'b00) e = 32'h0;
`endif
        check("pixel", fdata, e);
      end
      n_push++;
    end
    check("credit", 32'(dbg_credit), 32'(m_credit));
    check("error", 32'(err), 32'(m_err));
    if (p_valid && !p_hs) begin
      check("ar_hold_valid", 32'(arvalid), 32'(1));
      check("ar_hold_addr", araddr, p_addr);
    end
    if (!p_valid && arvalid)
      check("ar_permit", 32'(p_credit >= BL && p_out < MO && p_en), 32'(1));
    if (ar_hs) begin
      check("araddr", araddr, m_base + m_off);
      check("frame_start", 32'(fstart), 32'(m_off == 0));
      check("arlen", 32'(arlen), 32'(BL - 1));
      check("arburst", 32'(arburst), 32'(1));
      check("arid", 32'(arid), 32'(0));
      ar_log.push_back(araddr);
      n_ar++;
      if (n_ar == 3) n_rlast_at_ar3 = n_rlast;
      for (int i = 0; i < BL; i++) exp_q.push_back(pix(m_base + m_off + 32'(4 * i)));
      m_off = m_off + 32'(BL * 4);
      if (m_off >= m_size) begin
        m_off  = '0;
        m_base = frame_base;
        m_size = frame_size;
      end
    end else begin
      check("frame_start_quiet", 32'(fstart), 32'(0));
    end
    p_valid  = arvalid;
    p_hs     = ar_hs;
    p_addr   = araddr;
    p_credit = m_credit;
    p_out    = m_out;
    p_en     = enable;
    m_credit = m_credit - (ar_hs ? BL : 0) + int'(fpop);
    if (m_credit > DEPTH) m_credit = DEPTH;
    if (ar_hs) m_out++;
    if (r_hs && rlast) begin
      m_out--;
      n_rlast++;
    end
`ifdef VGA_FETCH_RESP_CHECK_EN
    if (r_hs && rresp != 2'b00) m_err = 1'b1;
`endif
  endtask

  // AXI read slave and FIFO consumer, driven just after the rising edge
  task automatic drive_slave();
    cyc++;
    if (!rst_n) begin
      s_q.delete();
      s_beat = 0;
      rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = '0;
      arready = ar_rdy; fpop = 1'b0; faccept = 1'b1;
      s_ar_hs = 1'b0; s_r_hs = 1'b0; s_err_inj = 1'b0;
      return;
    end
    if (s_ar_hs) s_q.push_back(s_ar_addr);
    if (s_r_hs) begin
      if (s_err_inj) err_done++;
      if (s_beat == BL - 1) begin
        s_beat = 0;
        void'(s_q.pop_front());
      end else begin
        s_beat++;
      end
    end
    rvalid = r_on && (s_q.size() > 0);
    if (rvalid) begin
      rdata = pix(s_q[0] + 32'(4 * s_beat));
      rlast = (s_beat == BL - 1);
      rresp = (err_req > err_done) ? 2'b10 : 2'b00;
    end else begin
      rdata = '0; rlast = 1'b0; rresp = 2'b00;
    end
    arready = ar_rdy;
    fpop    = pop_on || (pop_req > pop_done);
    if (!pop_on && pop_req > pop_done) pop_done++;
    faccept = acc_tog ? (cyc % 3 != 0) : 1'b1;
  endtask

  always begin
    @(negedge clk);
    if (rst_n) model_cycle();
    @(posedge clk);
    #1;
    drive_slave();
  end

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n  = 1'b0;
    enable = 1'b0;
    #1;
    check("rst_arvalid", 32'(arvalid), 32'(0));
    check("rst_araddr", araddr, 32'h0);
    check("rst_frame_start", 32'(fstart), 32'(0));
    check("rst_error", 32'(err), 32'(0));
    check("rst_state", 32'(dbg_state), 32'(0));
    check("rst_credit", 32'(dbg_credit), 32'(DEPTH));
    exp_q.delete(); ar_log.delete();
    m_credit = DEPTH; m_out = 0; m_err = 1'b0; m_off = '0;
    p_valid = 1'b0; p_hs = 1'b0; p_en = 1'b0; p_credit = DEPTH; p_out = 0;
    n_ar = 0; n_rlast = 0; n_push = 0; n_rlast_at_ar3 = -1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic start(input logic [31:0] b, input logic [31:0] s);
    @(posedge clk);
    #1;
    frame_base = b; frame_size = s;
    m_base = b; m_size = s; m_off = '0;
    enable = 1'b1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int i = 0; i < budget && dbg_state != 2'd0; i++) begin
      @(posedge clk);
      #1;
    end
    check(name, 32'(dbg_state), 32'(0));
  endtask

  initial begin
    logic [31:0] held;
    int          base_push;
    #2 rst_n = 1'b0;
    do_reset();

    // two bursts then stall on the outstanding limit, no read data returned
    ar_rdy = 1'b1; r_on = 1'b0; pop_on = 1'b0;
    start(32'h1000, 32'd128);
    repeat (20) @(posedge clk);
    #1;
    check("t1_ar_count", 32'(n_ar), 32'(2));
    check("t1_ar0", log_at(0), 32'h1000);
    check("t1_ar1", log_at(1), 32'h1040);
    check("t1_credit", 32'(dbg_credit), 32'(991));
    check("t1_stalled", 32'(arvalid), 32'(0));

    // third request only after the first burst completes
    r_on = 1'b1;
    for (int i = 0; i < 100 && n_ar < 3; i++) begin
      @(posedge clk);
      #1;
    end
    check("t2_ar_count", 32'(n_ar), 32'(3));
    check("t2_rlast_before_ar3", 32'(n_rlast_at_ar3), 32'(1));
    check("t2_ar2_wrap", log_at(2), 32'h1000);

    // continuous pops with a throttled then free-running FIFO accept
    pop_on = 1'b1; acc_tog = 1'b1;
    repeat (60) @(posedge clk);
    acc_tog = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    check("t3_progress", 32'(n_ar >= 8), 32'(1));
    for (int i = 0; i < 8; i++)
      check($sformatf("t3_seq%0d", i), log_at(i), (i % 2 == 1) ? 32'h1040 : 32'h1000);

    // enable drops while a request waits on arready
    ar_rdy = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 100 && !arvalid; i++) begin
      @(posedge clk);
      #1;
    end
    check("t4_arvalid_up", 32'(arvalid), 32'(1));
    held   = araddr;
    enable = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("t4_held_valid", 32'(arvalid), 32'(1));
    check("t4_held_addr", araddr, held);
    check("t4_drain", 32'(dbg_state), 32'(2));
    ar_rdy = 1'b1;
    wait_idle("t4_idle", 300);
    check("t4_last_ar", log_at(ar_log.size() - 1), held);
    check("t4_all_pushed", 32'(exp_q.size()), 32'(0));

    // credit exhaustion, single-pop refill and saturation
    do_reset();
    pop_on = 1'b0; r_on = 1'b1;
    start(32'h2000, 32'd256);
    repeat (1300) @(posedge clk);
    #1;
    check("t5_ar_count", 32'(n_ar), 32'(63));
    check("t5_credit", 32'(dbg_credit), 32'(15));
    check("t5_no_ar", 32'(arvalid), 32'(0));
    pop_req++;
    repeat (10) @(posedge clk);
    #1;
    check("t5_ar_after_pop", 32'(n_ar), 32'(64));
    check("t5_credit_zero", 32'(dbg_credit), 32'(0));
    enable = 1'b0;
    wait_idle("t5_idle", 300);
    pop_on = 1'b1;
    repeat (1100) @(posedge clk);
    #1;
    check("t5_credit_sat", 32'(dbg_credit), 32'(DEPTH));

    // reset in the middle of a burst, then restart from the frame base
    start(32'h3000, 32'd128);
    base_push = n_push;
    for (int i = 0; i < 100 && n_push < base_push + 5; i++) begin
      @(posedge clk);
      #1;
    end
    check("t6_mid_burst", 32'(n_push >= base_push + 5), 32'(1));
    do_reset();
    start(32'h3000, 32'd128);
    repeat (10) @(posedge clk);
    #1;
    check("t6_restart_addr", log_at(0), 32'h3000);

    // one errored beat
    err_req++;
    repeat (60) @(posedge clk);
    #1;
    check("t7_error", 32'(err), 32'(EXP_ERR));
    check("t7_err_beat_done", 32'(err_done), 32'(1));
    enable = 1'b0;
    wait_idle("t7_idle", 300);
    check("t7_error_sticky", 32'(err), 32'(EXP_ERR));
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vga_framebuffer_fetch.md
VGA_FRAMEBUFFER_FETCH -- requirements
Module: vga_framebuffer_fetch

Interface
REQ-001 Parameter BURST_LEN, default 16, words per AXI read burst (power of 2, 1..16).
REQ-002 Parameter FIFO_DEPTH, default 1023, usable word capacity of the downstream pixel FIFO.
REQ-003 Parameter MAX_OUTSTANDING, default 2, maximum bursts issued but not yet completed (RLAST).
REQ-004 clk_i  input  1  single clock for all logic.
REQ-005 rst_i  input  1  reset, asynchronous assertion, active-low.
REQ-006 enable_i  input  1  fetch enable, level.
REQ-007 frame_base_i  input  32  frame buffer byte address, 64-byte aligned.
REQ-008 frame_size_i  input  32  frame size in bytes, non-zero multiple of BURST_LEN*4.
REQ-009 axi_arvalid_o / axi_arready_i  out/in  1/1  AR handshake.
REQ-010 axi_araddr_o  output  32  burst start address.
REQ-011 axi_arlen_o / axi_arburst_o / axi_arid_o  output  8/2/4  BURST_LEN-1, INCR (2'b01), 4'd0.
REQ-012 axi_rvalid_i / axi_rready_o  in/out  1/1  R handshake.
REQ-013 axi_rdata_i / axi_rresp_i / axi_rlast_i  input  32/2/1  read data, response, last beat.
REQ-014 fifo_data_o / fifo_push_o / fifo_accept_i  out/out/in  32/1/1  push side of pixel FIFO.
REQ-015 fifo_pop_i  input  1  pixel FIFO pop strobe (consumer side), used for credit return.
REQ-016 frame_start_o  output  1  one-cycle pulse when the first burst of a frame is accepted.
REQ-017 error_o  output  1  sticky read-error flag.

Function
REQ-018 States: IDLE, ACTIVE, DRAIN; IDLE->ACTIVE on enable_i=1; ACTIVE->DRAIN on enable_i=0; DRAIN->IDLE when outstanding count is 0.
REQ-019 On IDLE->ACTIVE: frame_base_i and frame_size_i latched, address pointer = base, offset = 0.
REQ-020 Credit counter (width clog2(FIFO_DEPTH+1)) resets to FIFO_DEPTH; -BURST_LEN on AR handshake; +1 per fifo_pop_i; both in one cycle apply net.
REQ-021 axi_arvalid_o asserts in ACTIVE only when credit >= BURST_LEN and outstanding < MAX_OUTSTANDING.
REQ-022 Once asserted, axi_arvalid_o and axi_araddr_o hold stable until axi_arready_i, even if enable_i falls.
REQ-023 Outstanding counter: +1 on AR handshake, -1 on R handshake with axi_rlast_i; simultaneous events net to no change.
REQ-024 After AR handshake offset += BURST_LEN*4; if new offset >= latched size: offset = 0, base/size re-latched from inputs (double buffering), address = new base.
REQ-025 frame_start_o pulses in the cycle of an AR handshake with offset 0.
REQ-026 axi_rready_o = fifo_accept_i; fifo_push_o = axi_rvalid_i & fifo_accept_i; fifo_data_o = axi_rdata_i (combinational pass-through, zero latency).
REQ-027 Read beats still in flight in DRAIN are pushed normally; no AR issued in DRAIN or IDLE.
REQ-028 Credit scheme guarantees fifo_accept_i is never required to be low; logic remains correct if it is.
REQ-029 Credit counter never exceeds FIFO_DEPTH; pops beyond that saturate.

Reset
REQ-030 Reset values: state IDLE, axi_arvalid_o 0, axi_araddr_o 0, credit FIFO_DEPTH, outstanding 0, offset 0, frame_start_o 0, error_o 0.
REQ-031 Reset mid-burst abandons in-flight transactions; the FIFO shares the same reset.
REQ-032 Reset assertion is asynchronous; deassertion is synchronised externally to clk_i.

Configuration
REQ-033 Macro VGA_FETCH_RESP_CHECK_EN defined: any R beat with axi_rresp_i != 0 sets error_o (sticky until reset) and pushes 32'h0 instead of data.
REQ-034 Macro VGA_FETCH_RESP_CHECK_EN undefined: axi_rresp_i ignored, error_o tied 0, data always passed through.

Verification
REQ-035 base=0x1000, size=128, BURST_LEN=16, arready=1, no pops -> ARs at 0x1000 and 0x1040, arlen=15, then stall with credit 991 until pops.
REQ-036 Continuous pops, size=128 -> AR sequence 0x1000, 0x1040, 0x1000, ...; frame_start_o pulses at every 0x1000 handshake.
REQ-037 arready held low 5 cycles while enable_i drops -> arvalid/araddr stable until handshake, then DRAIN, 16 beats pushed, IDLE.
REQ-038 MAX_OUTSTANDING=2, rvalid withheld -> exactly 2 ARs issued; third only after first RLAST beat.
REQ-039 VGA_FETCH_RESP_CHECK_EN defined, one beat rresp=2'b10 -> that push carries 0, error_o=1 and stays set until rst_i low.
REQ-040 rst_i low mid-burst -> all outputs return to reset values asynchronously, next enable restarts at frame_base_i.
